// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key scheduler and round sequencer.
// Ports: clk/rst, start/decrypt/key request, hold backpressure;
//   busy/load_block/done strobes, round index, subkey, final_round.
module des_key_sched_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic        hold,
    output logic        busy,
    output logic        load_block,
    output logic        subkey_valid,
    output logic [3:0]  round,
    output logic [47:0] subkey,
    output logic        final_round,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_DONE
    } state_t;

    // FIPS 46-3 PC-1, bit 1 = key[63]
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1,
        58, 50, 42, 34, 26, 18, 10,  2,
        59, 51, 43, 35, 27, 19, 11,  3,
        60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7,
        62, 54, 46, 38, 30, 22, 14,  6,
        61, 53, 45, 37, 29, 21, 13,  5,
        28, 20, 12,  4
    };

    // FIPS 46-3 PC-2, bit 1 = C[27]
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28,
        15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56,
        34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit r set when the shift schedule entry S[r] is 2, else 1
    localparam logic [15:0] SHIFT2 = 16'h7EFC;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [27:0] w_c_nxt;
    logic [27:0] w_d_nxt;
    logic        r_dir;
    logic        w_dir_nxt;
    logic [3:0]  r_rnd;
    logic [3:0]  w_rnd_nxt;
    logic [3:0]  w_rnd_inc;
    logic        w_sh_enc;
    logic        w_sh_dec;
    logic [55:0] w_pc1;
    logic [55:0] w_cd;
    logic [47:0] w_pc2;

    function automatic logic [27:0] f_rotl(input logic [27:0] v,
                                           input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] f_rotr(input logic [27:0] v,
                                           input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign w_pc1[55-g] = key[64-PC1[g]];
    end

    assign w_cd = {r_c, r_d};

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign w_pc2[47-g] = w_cd[56-PC2[g]];
    end

    assign w_rnd_inc = r_rnd + 4'd1;
    // Encrypt steps forward through the table, decrypt walks it backwards
    assign w_sh_enc  = SHIFT2[w_rnd_inc];
    assign w_sh_dec  = SHIFT2[4'd15 - r_rnd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_dir   <= 1'b0;
            r_rnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_dir   <= w_dir_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_dir_nxt   = r_dir;
        w_rnd_nxt   = r_rnd;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_c_nxt     = w_pc1[55:28];
                    w_d_nxt     = w_pc1[27:0];
                    w_dir_nxt   = decrypt;
                    w_rnd_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // Decrypt starts from C0/D0, which equals C16/D16
                if (!r_dir) begin
                    w_c_nxt = f_rotl(r_c, 1'b0);
                    w_d_nxt = f_rotl(r_d, 1'b0);
                end
                w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                if (!hold) begin
                    if (r_rnd == 4'd15) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rnd_nxt = w_rnd_inc;
                        if (r_dir) begin
                            w_c_nxt = f_rotr(r_c, w_sh_dec);
                            w_d_nxt = f_rotr(r_d, w_sh_dec);
                        end else begin
                            w_c_nxt = f_rotl(r_c, w_sh_enc);
                            w_d_nxt = f_rotl(r_d, w_sh_enc);
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy         = (r_state == S_LOAD) || (r_state == S_ROUND);
    assign load_block   = (r_state == S_LOAD);
    assign subkey_valid = (r_state == S_ROUND);
    assign done         = (r_state == S_DONE);
    assign round        = subkey_valid ? r_rnd : 4'd0;
    assign subkey       = subkey_valid ? w_pc2 : 48'd0;
    assign final_round  = subkey_valid && (r_rnd == 4'd15);

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl.
// Scoreboard of expected subkeys, directed steps, immediate assertions.
module tb_des_key_sched_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        hold;
    logic        busy;
    logic        load_block;
    logic        subkey_valid;
    logic [3:0]  round;
    logic [47:0] subkey;
    logic        final_round;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [47:0] sb_q[$];

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [47:0] KA_1   = 48'h1B02EFFC7072;
    localparam logic [47:0] KA_16  = 48'hCB3D8B0E17F5;

    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SCHED [0:15] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    des_key_sched_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .hold         (hold),
        .busy         (busy),
        .load_block   (load_block),
        .subkey_valid (subkey_valid),
        .round        (round),
        .subkey       (subkey),
        .final_round  (final_round),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference subkey Kn (n = 1..16) from cumulative rotation of C0/D0
    function automatic logic [47:0] model_subkey(input logic [63:0] k,
                                                 input int n);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] ks;
        int tot;
        tot = 0;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1[i]];
            d[27-i] = k[64-PC1[28+i]];
        end
        for (int j = 0; j < n; j++) tot += SCHED[j];
        for (int j = 0; j < tot; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) ks[47-i] = cd[56-PC2[i]];
        return ks;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_load"}, load_block, 0);
        chk({tag, "_valid"}, subkey_valid, 0);
        chk({tag, "_round"}, round, 0);
        chk({tag, "_subkey"}, subkey, 0);
        chk({tag, "_final"}, final_round, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_op(input logic [63:0] k, input logic dec,
                          input int hold_at, input int hold_n,
                          input int start_at, input int exp_done,
                          input bit chk_ends, input logic [47:0] first,
                          input logic [47:0] last);
        int cyc;
        int r;
        int held;
        bit seen;
        for (int i = 0; i < 16; i++)
            sb_q.push_back(model_subkey(k, dec ? 16 - i : i + 1));
        key     = k;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        chk("load_block", load_block, 1);
        chk("busy_load", busy, 1);
        chk("valid_load", subkey_valid, 0);
        r    = 0;
        held = 0;
        seen = 1'b0;
        tick();
        cyc = 2;
        while (cyc <= 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
                chk("done_cycle", cyc, exp_done);
                chk("busy_done", busy, 0);
            end else if (subkey_valid) begin
                chk("busy_round", busy, 1);
                chk("round_idx", round, r);
                chk("final_round", final_round, r == 15);
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) chk("subkey", subkey, sb_q[0]);
                if (chk_ends && r == 0) chk("subkey_first", subkey, first);
                if (chk_ends && r == 15) chk("subkey_last", subkey, last);
                if (r == start_at) start = 1'b1;
                if (r == hold_at && held < hold_n) begin
                    hold = 1'b1;
                    held++;
                end else begin
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                    r++;
                end
            end
            tick();
            cyc++;
            hold  = 1'b0;
            start = 1'b0;
        end
        chk("done_seen", seen, 1);
        chk("sb_drained", sb_q.size(), 0);
        sb_q.delete();
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        int cyc;
        int dn_cnt;
        int dtimes [0:2];
        bit found;
        bit act;

        rst     = 1'b1;
        start   = 1'b0;
        decrypt = 1'b0;
        key     = '0;
        hold    = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        run_op(KEY_A, 1'b0, -1, 0, -1, 18, 1'b1, KA_1, KA_16);
        run_op(KEY_A, 1'b1, -1, 0, -1, 18, 1'b1, KA_16, KA_1);
        run_op(64'h0, 1'b0, -1, 0, -1, 18, 1'b1, 48'h0, 48'h0);
        run_op(64'h0101010101010101, 1'b0, -1, 0, -1, 18, 1'b1,
               48'h0, 48'h0);
        run_op(KEY_A, 1'b0, 5, 3, -1, 21, 1'b0, 48'h0, 48'h0);
        run_op(KEY_A, 1'b0, -1, 0, 7, 18, 1'b0, 48'h0, 48'h0);

        // Abort mid-run with reset
        key     = KEY_A;
        decrypt = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (subkey_valid && round == 4'd9) found = 1'b1;
            else tick();
        end
        chk("reach_round9", found, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("abort");
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) act = 1'b1;
        end
        chk("no_done_after_rst", act, 0);
        run_op(KEY_A, 1'b0, -1, 0, -1, 18, 1'b1, KA_1, KA_16);

        // start tied high, decrypt flipped during the first run
        sb_q.push_back(model_subkey(KEY_A, 1));
        sb_q.push_back(model_subkey(KEY_A, 16));
        sb_q.push_back(model_subkey(KEY_A, 16));
        key     = KEY_A;
        decrypt = 1'b0;
        start   = 1'b1;
        cyc     = 0;
        dn_cnt  = 0;
        while (cyc < 80 && dn_cnt < 3) begin
            tick();
            cyc++;
            if (cyc == 5) decrypt = 1'b1;
            if (subkey_valid && round == 4'd0) begin
                chk("th_sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) chk("th_subkey0", subkey,
                                          sb_q.pop_front());
            end
            if (done) begin
                dtimes[dn_cnt] = cyc;
                dn_cnt++;
                if (dn_cnt == 3) start = 1'b0;
            end
        end
        chk("th_done_count", dn_cnt, 3);
        if (dn_cnt == 3) begin
            chk("th_done0", dtimes[0], 18);
            chk("th_done1", dtimes[1], 37);
            chk("th_done2", dtimes[2], 56);
        end
        chk("th_sb_drained", sb_q.size(), 0);
        decrypt = 1'b0;
        tick();
        tick();
        chk("th_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
